// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer: circular retirement-trace capture with PC trigger, post-trigger window and watchdog
module pipeline_trace_buffer #(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CYCLE_LIMIT = 200,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              trig_pc_en,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [CW-1:0]     post_cnt,
    input  logic              filt_nop,
    input  logic              tr_valid,
    input  logic [PC_W-1:0]   tr_pc,
    input  logic [31:0]       tr_instr,
    input  logic [DATA_W-1:0] tr_wd,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [PC_W-1:0]   rd_pc,
    output logic [31:0]       rd_instr,
    output logic [DATA_W-1:0] rd_wd,
    output logic [CW-1:0]     count,
    output logic [1:0]        state,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_cnt
);
    localparam int EW = PC_W + 32 + DATA_W;
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3;

    logic [1:0]    r_state, w_next;
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, r_remain;
    logic [31:0]   r_cycle_cnt;
    logic          r_timeout;
    logic          w_acc, w_capt, w_wr, w_trig, w_dec, w_complete, w_wdog, w_arm, w_pop;
    logic [CW-1:0] w_post_eff;
    logic [EW-1:0] w_rd_word;

    assign w_acc      = tr_valid && !(filt_nop && tr_instr == 32'h0);
    assign w_capt     = (r_state == ARMED) || (r_state == POST);
    assign w_wr       = w_capt && w_acc;
    assign w_trig     = (r_state == ARMED) && w_acc && (!trig_pc_en || tr_pc == trig_pc);
    assign w_dec      = w_trig || ((r_state == POST) && w_acc);
    assign w_complete = w_dec && (r_remain == CW'(1));
    assign w_wdog     = w_capt && (r_cycle_cnt == 32'(CYCLE_LIMIT - 1)) && !w_complete;
    assign w_arm      = arm && ((r_state == IDLE) || (r_state == DONE));
    assign w_pop      = (r_state == DONE) && rd_en && (r_count != '0) && !arm;
    assign w_post_eff = (post_cnt == '0 || post_cnt > CW'(DEPTH)) ? CW'(DEPTH) : post_cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: completion outranks the watchdog, both end capture
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = arm ? ARMED : IDLE;
            ARMED:   w_next = (w_complete || w_wdog) ? DONE : (w_trig ? POST : ARMED);
            POST:    w_next = (w_complete || w_wdog) ? DONE : POST;
            default: w_next = arm ? ARMED : DONE;
        endcase
    end

    // Outputs: read port is only live once capture has finished
    always_comb begin
        done      = (r_state == DONE);
        rd_valid  = done && (r_count != '0);
        w_rd_word = rd_valid ? r_mem[r_rd_ptr] : '0;
        {rd_pc, rd_instr, rd_wd} = w_rd_word;
    end

    // Trace storage; contents need no reset because rd_valid gates the read port
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {tr_pc, tr_instr, tr_wd};
    end

    // Pointers and occupancy: a full buffer overwrites its oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_arm) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_count == CW'(DEPTH)) r_rd_ptr <= r_rd_ptr + 1'b1;
            else                       r_count  <= r_count + 1'b1;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count - 1'b1;
        end
    end

    // Window countdown, watchdog counter and timeout flag; the counter freezes on the edge entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remain    <= '0;
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
        end else if (w_arm) begin
            r_remain    <= w_post_eff;
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_dec) r_remain <= r_remain - 1'b1;
            if (w_capt && w_next != DONE) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_wdog) r_timeout <= 1'b1;
        end
    end

    assign count     = r_count;
    assign state     = r_state;
    assign timeout   = r_timeout;
    assign cycle_cnt = r_cycle_cnt;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb_pipeline_trace_buffer: directed checks of capture, trigger, wrap, watchdog, filter and reset
module tb_pipeline_trace_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0, trig_pc_en = 1'b0, filt_nop = 1'b0, tr_valid = 1'b0, rd_en = 1'b0;
    logic [31:0] trig_pc = '0, tr_pc = '0, tr_instr = '0, tr_wd = '0;
    logic [4:0]  post_cnt = '0;
    logic        rd_valid, done, timeout;
    logic [31:0] rd_pc, rd_instr, rd_wd, cycle_cnt;
    logic [4:0]  count;
    logic [1:0]  state;
    int          n_chk = 0, n_pass = 0;

    pipeline_trace_buffer dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
        .post_cnt(post_cnt), .filt_nop(filt_nop), .tr_valid(tr_valid), .tr_pc(tr_pc),
        .tr_instr(tr_instr), .tr_wd(tr_wd), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wd(rd_wd), .count(count), .state(state),
        .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic en, input logic [31:0] tpc, input logic [4:0] pc_n);
        trig_pc_en = en; trig_pc = tpc; post_cnt = pc_n; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic ent(input logic [31:0] pc, input logic [31:0] ins);
        tr_valid = 1'b1; tr_pc = pc; tr_instr = ins; tr_wd = pc ^ 32'hA5A5_0000;
        tick();
        tr_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_rd_pc", rd_pc, 0);
        tick();
        rst = 1'b0;
        tick();
        // immediate trigger, window of 4
        do_arm(1'b0, 32'h0, 5'd4);
        chk("t1_armed", 32'(state), 1);
        chk("t1_cycle0", cycle_cnt, 0);
        ent(32'h00, 32'h1111_0000);
        chk("t1_post", 32'(state), 2);
        ent(32'h04, 32'h1111_0004);
        ent(32'h08, 32'h1111_0008);
        chk("t1_still_post", 32'(state), 2);
        ent(32'h0C, 32'h1111_000C);
        chk("t1_done", 32'(state), 3);
        chk("t1_done_flag", 32'(done), 1);
        ent(32'h10, 32'h1111_0010);
        chk("t1_count", 32'(count), 4);
        chk("t1_timeout", 32'(timeout), 0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rd_valid", 32'(rd_valid), 1);
            chk("t1_rd_pc", rd_pc, 32'(4 * i));
            chk("t1_rd_instr", rd_instr, 32'h1111_0000 + 32'(4 * i));
            chk("t1_rd_wd", rd_wd, 32'(4 * i) ^ 32'hA5A5_0000);
            pop();
        end
        chk("t1_empty", 32'(rd_valid), 0);
        chk("t1_empty_pc", rd_pc, 0);
        pop();
        chk("t1_pop_empty_count", 32'(count), 0);
        // PC trigger with wrap
        do_arm(1'b1, 32'h40, 5'd3);
        rd_en = 1'b1;
        for (int i = 0; i <= 18; i++) begin
            ent(32'(4 * i), 32'h2000_0000 + 32'(i));
            if (i == 15) chk("t2_no_pop_capture", 32'(count), 16);
            if (i == 16) chk("t2_post", 32'(state), 2);
        end
        rd_en = 1'b0;
        chk("t2_done", 32'(state), 3);
        chk("t2_count", 32'(count), 16);
        chk("t2_oldest", rd_pc, 32'h0C);
        for (int i = 0; i < 13; i++) pop();
        chk("t2_trig_entry", rd_pc, 32'h40);
        pop(); pop();
        chk("t2_newest", rd_pc, 32'h48);
        chk("t2_newest_instr", rd_instr, 32'h2000_0012);
        // watchdog under continuous stream
        do_arm(1'b1, 32'hFFFC, 5'd0);
        chk("t3_rearm_count", 32'(count), 0);
        for (int i = 0; i < 200; i++) begin
            ent(32'(4 * i), 32'h3000_0000 + 32'(i));
            if (i == 198) chk("t3_before_wd", 32'(state), 1);
        end
        chk("t3_done", 32'(state), 3);
        chk("t3_timeout", 32'(timeout), 1);
        chk("t3_cycle", cycle_cnt, 199);
        chk("t3_count", 32'(count), 16);
        chk("t3_oldest", rd_pc, 32'h2E0);
        // completion on the watchdog cycle
        do_arm(1'b0, 32'h0, 5'd1);
        begin
            int n = 0;
            while (cycle_cnt != 199 && n < 400) begin
                tick();
                n++;
            end
            chk("t4_reach_199", cycle_cnt, 199);
        end
        chk("t4_armed", 32'(state), 1);
        ent(32'h500, 32'h4000_0000);
        chk("t4_done", 32'(state), 3);
        chk("t4_timeout", 32'(timeout), 0);
        chk("t4_count", 32'(count), 1);
        chk("t4_pc", rd_pc, 32'h500);
        // NOP filter
        filt_nop = 1'b1;
        do_arm(1'b1, 32'h100, 5'd2);
        ent(32'h000, 32'h2008_0005);
        ent(32'h100, 32'h0);
        chk("t5_nop_no_trig", 32'(state), 1);
        chk("t5_nop_not_stored", 32'(count), 1);
        ent(32'h008, 32'h2008_0005);
        ent(32'h100, 32'h2008_0005);
        chk("t5_trig", 32'(state), 2);
        ent(32'h104, 32'h0);
        chk("t5_nop_no_dec", 32'(state), 2);
        chk("t5_count3", 32'(count), 3);
        ent(32'h108, 32'h2008_0005);
        chk("t5_done", 32'(state), 3);
        chk("t5_count4", 32'(count), 4);
        chk("t5_oldest", rd_pc, 32'h000);
        pop();
        chk("t5_second", rd_pc, 32'h008);
        filt_nop = 1'b0;
        // reset mid-POST
        do_arm(1'b0, 32'h0, 5'd4);
        ent(32'h10, 32'h5000_0000);
        chk("t6_post", 32'(state), 2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_state", 32'(state), 0);
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_cycle", cycle_cnt, 0);
        chk("t6_rst_done", 32'(done), 0);
        chk("t6_rst_rd_valid", 32'(rd_valid), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_idle_hold", 32'(state), 0);
        // re-arm in DONE with a simultaneous pop
        do_arm(1'b0, 32'h0, 5'd5);
        for (int i = 0; i < 5; i++) ent(32'h600 + 32'(4 * i), 32'h6000_0000);
        chk("t6_done5", 32'(state), 3);
        chk("t6_count5", 32'(count), 5);
        arm = 1'b1; rd_en = 1'b1;
        tick();
        arm = 1'b0; rd_en = 1'b0;
        chk("t6_rearm_state", 32'(state), 1);
        chk("t6_rearm_count", 32'(count), 0);
        chk("t6_rearm_cycle", cycle_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
